// File: rtl/btb_if.sv
// Fetch-side lookup and decode-side update/flush bundle for the branch target buffer.
interface btb_if;
    logic [31:0] IF_PC;
    logic        IF_BTBHit;
    logic [31:0] IF_PredictedPC;
    logic        IF_HitIsJump;
    logic        ID_Update;
    logic [31:0] ID_PC;
    logic [31:0] ID_Target;
    logic        ID_BranchTaken;
    logic        ID_IsJump;
    logic        ID_FlushBTB;
    logic        BTB_Busy;

    modport master (
        output IF_PC,
        output ID_Update,
        output ID_PC,
        output ID_Target,
        output ID_BranchTaken,
        output ID_IsJump,
        output ID_FlushBTB,
        input  IF_BTBHit,
        input  IF_PredictedPC,
        input  IF_HitIsJump,
        input  BTB_Busy
    );

    modport slave (
        input  IF_PC,
        input  ID_Update,
        input  ID_PC,
        input  ID_Target,
        input  ID_BranchTaken,
        input  ID_IsJump,
        input  ID_FlushBTB,
        output IF_BTBHit,
        output IF_PredictedPC,
        output IF_HitIsJump,
        output BTB_Busy
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational fetch lookup, taken-only update from ID,
// and a one-entry-per-cycle invalidation sweep.
module branch_target_buffer #(
    parameter int INDEX_WIDTH = 3,
    parameter int TAG_WIDTH   = 8
) (
    input logic   clk,
    input logic   rst_n,
    btb_if.slave  bus
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_LO  = INDEX_WIDTH + 2;
    localparam int TAG_HI  = INDEX_WIDTH + TAG_WIDTH + 1;
    localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(ENTRIES - 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [INDEX_WIDTH-1:0] cnt_q;
    logic [INDEX_WIDTH-1:0] cnt_d;
    logic                   clr_en;
    logic                   wr_en;

    logic [ENTRIES-1:0]     valid_q;
    logic [ENTRIES-1:0]     jump_q;
    logic [TAG_WIDTH-1:0]   tag_q    [ENTRIES];
    logic [31:0]            target_q [ENTRIES];

    logic [INDEX_WIDTH-1:0] rd_idx;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [INDEX_WIDTH-1:0] wr_idx;
    logic [TAG_WIDTH-1:0]   wr_tag;
    logic                   busy;
    logic                   hit;

    assign rd_idx = bus.IF_PC[INDEX_WIDTH+1:2];
    assign rd_tag = bus.IF_PC[TAG_HI:TAG_LO];
    assign wr_idx = bus.ID_PC[INDEX_WIDTH+1:2];
    assign wr_tag = bus.ID_PC[TAG_HI:TAG_LO];

    // PC bits outside index/tag take no part in the lookup
    logic unused_pc;
    assign unused_pc = ^{bus.IF_PC, bus.ID_PC};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ID_FlushBTB) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (bus.ID_Update && bus.ID_BranchTaken) begin
                    wr_en = 1'b1;
                end
            end
            FLUSH: begin
                clr_en = 1'b1;
                if (bus.ID_FlushBTB) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            jump_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (clr_en) begin
                valid_q[cnt_q] <= 1'b0;
            end else if (wr_en) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= bus.ID_Target;
                jump_q[wr_idx]   <= bus.ID_IsJump;
            end
        end
    end

    // Lookups are suppressed for the whole sweep, not just swept entries
    assign busy = (state_q == FLUSH);
    assign hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && !busy;

    assign bus.BTB_Busy       = busy;
    assign bus.IF_BTBHit      = hit;
    assign bus.IF_HitIsJump   = hit && jump_q[rd_idx];
    assign bus.IF_PredictedPC = hit ? target_q[rd_idx] : bus.IF_PC + 32'd4;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: vector table, flush and
// reset corner sequences, and random traffic against a behavioural model.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    btb_if bus();

    branch_target_buffer #(.INDEX_WIDTH(3), .TAG_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic        upd;
        logic [31:0] id_pc;
        logic [31:0] tgt;
        logic        taken;
        logic        jmp;
        logic        flush;
        logic        e_hit;
        logic [31:0] e_pred;
        logic        e_jump;
        logic        e_busy;
    } vec_t;

    // Behavioural model: entry contents plus remaining busy cycles
    bit          m_valid [8];
    int unsigned m_tag   [8];
    logic [31:0] m_tgt   [8];
    bit          m_jmp   [8];
    int          busy_left;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        busy_left = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic upd,
                         input logic [31:0] idpc, input logic [31:0] tgt,
                         input logic tk, input logic jp, input logic fl);
        @(negedge clk);
        bus.IF_PC          = pc;
        bus.ID_Update      = upd;
        bus.ID_PC          = idpc;
        bus.ID_Target      = tgt;
        bus.ID_BranchTaken = tk;
        bus.ID_IsJump      = jp;
        bus.ID_FlushBTB    = fl;
        #1;
    endtask

    task automatic check_model(input string tag);
        int unsigned idx;
        int unsigned t;
        bit          h;
        logic [31:0] p;
        idx = (bus.IF_PC >> 2) % 8;
        t   = (bus.IF_PC >> 5) % 256;
        h   = (busy_left == 0) && m_valid[idx] && (m_tag[idx] == t);
        p   = h ? m_tgt[idx] : bus.IF_PC + 32'd4;
        chk({tag, ".hit"},  {31'd0, bus.IF_BTBHit},    {31'd0, h});
        chk({tag, ".pred"}, bus.IF_PredictedPC,        p);
        chk({tag, ".jump"}, {31'd0, bus.IF_HitIsJump}, {31'd0, h && m_jmp[idx]});
        chk({tag, ".busy"}, {31'd0, bus.BTB_Busy},     {31'd0, busy_left > 0});
    endtask

    task automatic advance();
        int unsigned idx;
        @(posedge clk);
        idx = (bus.ID_PC >> 2) % 8;
        if (busy_left == 0) begin
            if (bus.ID_FlushBTB) begin
                for (int i = 0; i < 8; i++) m_valid[i] = 0;
                busy_left = 8;
            end else if (bus.ID_Update && bus.ID_BranchTaken) begin
                m_valid[idx] = 1;
                m_tag[idx]   = (bus.ID_PC >> 5) % 256;
                m_tgt[idx]   = bus.ID_Target;
                m_jmp[idx]   = bus.ID_IsJump;
            end
        end else if (bus.ID_FlushBTB) begin
            busy_left = 8;
        end else begin
            busy_left--;
        end
    endtask

    task automatic step(input string tag, input logic [31:0] pc,
                        input logic upd, input logic [31:0] idpc,
                        input logic [31:0] tgt, input logic tk,
                        input logic jp, input logic fl);
        drive(pc, upd, idpc, tgt, tk, jp, fl);
        check_model(tag);
        advance();
    endtask

    task automatic idle_lookup(input string tag, input logic [31:0] pc);
        step(tag, pc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i++) begin
            step("fill", 32'h0, 1'b1, 32'h1000 + 32'(i * 4),
                 32'h2000 + 32'(i * 16), 1'b1, 1'(i % 2), 1'b0);
        end
        for (int i = 0; i < 8; i++) idle_lookup("filled", 32'h1000 + 32'(i * 4));
    endtask

    vec_t vt [12];
    int   busy_seen;
    int   cyc;

    initial begin
        vt[0]  = '{32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0};
        vt[1]  = '{32'h108, 1, 32'h108, 32'h200, 1, 0, 0, 0, 32'h10C, 0, 0};
        vt[2]  = '{32'h108, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0};
        vt[3]  = '{32'h128, 0, 0, 0, 0, 0, 0, 0, 32'h12C, 0, 0};
        vt[4]  = '{32'h128, 1, 32'h128, 32'h40, 1, 1, 0, 0, 32'h12C, 0, 0};
        vt[5]  = '{32'h128, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 0};
        vt[6]  = '{32'h108, 0, 0, 0, 0, 0, 0, 0, 32'h10C, 0, 0};
        vt[7]  = '{32'h128, 1, 32'h128, 32'h999, 0, 0, 0, 1, 32'h40, 1, 0};
        vt[8]  = '{32'h128, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 0};
        vt[9]  = '{32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
        vt[10] = '{32'h108, 1, 32'h108, 32'h203, 1, 0, 0, 0, 32'h10C, 0, 0};
        vt[11] = '{32'h108, 0, 0, 0, 0, 0, 0, 1, 32'h203, 0, 0};

        bus.IF_PC = 32'h100;
        bus.ID_Update = 0;
        bus.ID_PC = 0;
        bus.ID_Target = 0;
        bus.ID_BranchTaken = 0;
        bus.ID_IsJump = 0;
        bus.ID_FlushBTB = 0;
        model_reset();
        #12;
        chk("rst.hit",  {31'd0, bus.IF_BTBHit}, 32'd0);
        chk("rst.pred", bus.IF_PredictedPC,      32'h104);
        chk("rst.busy", {31'd0, bus.BTB_Busy},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].if_pc, vt[i].upd, vt[i].id_pc, vt[i].tgt,
                  vt[i].taken, vt[i].jmp, vt[i].flush);
            chk($sformatf("vec%0d.hit", i),  {31'd0, bus.IF_BTBHit},    {31'd0, vt[i].e_hit});
            chk($sformatf("vec%0d.pred", i), bus.IF_PredictedPC,        vt[i].e_pred);
            chk($sformatf("vec%0d.jump", i), {31'd0, bus.IF_HitIsJump}, {31'd0, vt[i].e_jump});
            chk($sformatf("vec%0d.busy", i), {31'd0, bus.BTB_Busy},     {31'd0, vt[i].e_busy});
            advance();
        end

        // Flush sweep: busy exactly 8 cycles, mid-sweep update dropped
        fill_all();
        step("flreq", 32'h1000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        busy_seen = 0;
        cyc = 0;
        while (cyc < 20) begin
            drive(32'h1000 + 32'((cyc % 8) * 4), cyc == 3, 32'h1004,
                  32'h5555, 1'b1, 1'b0, 1'b0);
            if (bus.BTB_Busy) busy_seen++;
            check_model("flush");
            advance();
            cyc++;
            if (busy_seen > 0 && !bus.BTB_Busy) break;
        end
        chk("flush.busy_cycles", busy_seen, 8);
        for (int i = 0; i < 8; i++) begin
            drive(32'h1000 + 32'(i * 4), 0, 0, 0, 0, 0, 0);
            chk("after_flush.hit", {31'd0, bus.IF_BTBHit}, 32'd0);
            advance();
        end

        // Restart of a running sweep
        fill_all();
        step("flreq2", 32'h0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle_lookup("sweep2", 32'h1000);
        step("restart", 32'h1000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) idle_lookup("sweep2b", 32'h1000 + 32'(i * 4));

        // Reset in sweep cycle 3
        fill_all();
        step("flreq3", 32'h0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) idle_lookup("sweep3", 32'h1000);
        @(negedge clk);
        bus.IF_PC = 32'h1004;
        chk("midrst.busy_before", {31'd0, bus.BTB_Busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.busy", {31'd0, bus.BTB_Busy},  32'd0);
        chk("midrst.hit",  {31'd0, bus.IF_BTBHit}, 32'd0);
        chk("midrst.pred", bus.IF_PredictedPC,      32'h1008);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) idle_lookup("post_rst", 32'h1000 + 32'(i * 4));
        step("realloc", 32'h108, 1'b1, 32'h108, 32'h200, 1'b1, 1'b0, 1'b0);
        idle_lookup("realloc_hit", 32'h108);
        chk("realloc.pred", bus.IF_PredictedPC, 32'h200);
        idle_lookup("wrap", 32'hFFFF_FFFC);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc;
            logic [31:0] ipc;
            pc  = 32'h400 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, 7) << 2);
            ipc = 32'h400 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 49) == 0) pc = 32'hFFFF_FFFC;
            step("rand", pc, $urandom_range(0, 9) < 4, ipc, $urandom,
                 $urandom_range(0, 9) < 7, 1'($urandom),
                 $urandom_range(0, 99) < 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
